// File: rtl/r5fp_div_issue_pkg.sv
// Shared types for the R5FP divide issue/return path: float control word,
// queued divide request payload and issue controller state encoding.
package r5fp_div_issue_pkg;

  localparam int unsigned FP_W      = 65;
  localparam int unsigned DIV_TAG_W = 5;

  typedef struct packed {
    logic [2:0] rnd;
    logic       tininess;
    logic [4:0] flags;
  } float_ctrl_t;

  typedef struct packed {
    logic [FP_W-1:0]      a;
    logic [FP_W-1:0]      b;
    logic                 is_single;
    float_ctrl_t          fctrl;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } div_issue_state_t;

endpackage

// File: rtl/r5fp_div_req_fifo.sv
// In-order circular queue of divide requests; head is always presented.
module r5fp_div_req_fifo
  import r5fp_div_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  div_req_t               i_req,
  input  logic                   i_pop,
  output div_req_t               o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  div_req_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_req;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/r5fp_div_issue.sv
// Issue/return controller around R5FP_div_seq: queues requests, strobes the
// divider one op at a time, and holds each result for writeback.
module r5fp_div_issue
  import r5fp_div_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = DIV_TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FP_W-1:0]   req_a,
  input  logic [FP_W-1:0]   req_b,
  input  logic              req_is_single,
  input  float_ctrl_t       req_fctrl,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              div_strobe_in,
  output logic [FP_W-1:0]   div_a_in,
  output logic [FP_W-1:0]   div_b_in,
  output logic              div_is_single_in,
  output float_ctrl_t       div_fctrl_in,
  input  logic              div_valid_out,
  input  logic [FP_W-1:0]   div_result_out,
  input  float_ctrl_t       div_fctrl_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FP_W-1:0]   rsp_result,
  output float_ctrl_t       rsp_fctrl,
  output logic              rsp_is_single,
  output logic [TAG_W-1:0]  rsp_tag
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  div_issue_state_t r_state;
  div_issue_state_t w_state_nxt;
  logic             w_strobe_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_can_issue;
  div_req_t         w_req;
  div_req_t         w_head;
  logic [CNT_W-1:0] w_count;

  logic             r_strobe;
  logic             r_rsp_valid;
  logic [FP_W-1:0]  r_rsp_result;
  float_ctrl_t      r_rsp_fctrl;
  logic             r_rsp_is_single;
  logic [TAG_W-1:0] r_rsp_tag;

  assign req_ready = (w_count < CNT_W'(DEPTH));
  assign w_push    = req_valid && req_ready && !flush;

  always_comb begin
    w_req           = '0;
    w_req.a         = req_a;
    w_req.b         = req_b;
    w_req.is_single = req_is_single;
    w_req.fctrl     = req_fctrl;
    w_req.tag       = DIV_TAG_W'(req_tag);
  end

  r5fp_div_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_push  (w_push),
    .i_req   (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Only issue when the response register is free by the time the result returns.
  assign w_can_issue = (w_count != '0) && (!r_rsp_valid || rsp_ready) && !flush;

  always_comb begin
    w_state_nxt  = r_state;
    w_strobe_nxt = 1'b0;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_can_issue) begin
          w_state_nxt  = BUSY;
          w_strobe_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (div_valid_out) begin
          w_state_nxt = IDLE;
          if (!flush) begin
            w_capture = 1'b1;
            w_pop     = 1'b1;
          end
        end else if (flush) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The killed result is dropped; a request queued meanwhile may go straight out.
        if (div_valid_out) begin
          if (w_can_issue) begin
            w_state_nxt  = BUSY;
            w_strobe_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_strobe <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  // Response holding register; capture wins over a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid     <= 1'b0;
      r_rsp_result    <= '0;
      r_rsp_fctrl     <= '0;
      r_rsp_is_single <= 1'b0;
      r_rsp_tag       <= '0;
    end else if (flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_capture) begin
      r_rsp_valid     <= 1'b1;
      r_rsp_result    <= div_result_out;
      r_rsp_fctrl     <= div_fctrl_out;
      r_rsp_is_single <= w_head.is_single;
      r_rsp_tag       <= TAG_W'(w_head.tag);
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign div_strobe_in    = r_strobe;
  assign div_a_in         = w_head.a;
  assign div_b_in         = w_head.b;
  assign div_is_single_in = w_head.is_single;
  assign div_fctrl_in     = w_head.fctrl;

  assign rsp_valid     = r_rsp_valid;
  assign rsp_result    = r_rsp_result;
  assign rsp_fctrl     = r_rsp_fctrl;
  assign rsp_is_single = r_rsp_is_single;
  assign rsp_tag       = r_rsp_tag;

endmodule

// File: tb/tb_r5fp_div_issue.sv
// Scoreboard bench for r5fp_div_issue with a fixed-latency divider stub.
module tb_r5fp_div_issue;
  import r5fp_div_issue_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [64:0]      req_a;
  logic [64:0]      req_b;
  logic             req_is_single;
  float_ctrl_t      req_fctrl;
  logic [TAG_W-1:0] req_tag;
  logic             div_strobe_in;
  logic [64:0]      div_a_in;
  logic [64:0]      div_b_in;
  logic             div_is_single_in;
  float_ctrl_t      div_fctrl_in;
  logic             div_valid_out;
  logic [64:0]      div_result_out;
  float_ctrl_t      div_fctrl_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [64:0]      rsp_result;
  float_ctrl_t      rsp_fctrl;
  logic             rsp_is_single;
  logic [TAG_W-1:0] rsp_tag;

  r5fp_div_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_is_single(req_is_single), .req_fctrl(req_fctrl), .req_tag(req_tag),
    .div_strobe_in(div_strobe_in), .div_a_in(div_a_in), .div_b_in(div_b_in),
    .div_is_single_in(div_is_single_in), .div_fctrl_in(div_fctrl_in),
    .div_valid_out(div_valid_out), .div_result_out(div_result_out),
    .div_fctrl_out(div_fctrl_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_fctrl(rsp_fctrl), .rsp_is_single(rsp_is_single), .rsp_tag(rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Divider stub: result pulse 5 cycles after the strobe, a^b, flags 0x01.
  logic [64:0] s_a, s_b;
  float_ctrl_t s_fc;
  int          s_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt          <= 0;
      s_a            <= '0;
      s_b            <= '0;
      s_fc           <= '0;
      div_valid_out  <= 1'b0;
      div_result_out <= '0;
      div_fctrl_out  <= '0;
    end else begin
      div_valid_out <= 1'b0;
      if (div_strobe_in) begin
        s_a   <= div_a_in;
        s_b   <= div_b_in;
        s_fc  <= div_fctrl_in;
        s_cnt <= 4;
      end else if (s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
        if (s_cnt == 1) begin
          div_valid_out  <= 1'b1;
          div_result_out <= s_a ^ s_b;
          div_fctrl_out  <= '{rnd: s_fc.rnd, tininess: s_fc.tininess, flags: 5'h01};
        end
      end
    end
  end

  typedef struct packed {
    logic [64:0]      res;
    float_ctrl_t      fc;
    logic             sgl;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];

  logic        p_strobe, p_rsp_valid, p_rsp_ready, p_flush, outstanding;
  logic [79:0] p_rsp;
  int          n_strobes = 0;
  int          push_cyc = 0, strobe_cyc = 0, rise_cyc = 0;

  // Monitor: samples mid-cycle, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      p_strobe = 0; p_rsp_valid = 0; p_rsp_ready = 0; p_flush = 0; outstanding = 0;
    end else begin
      if (p_rsp_valid && !p_rsp_ready && !p_flush) begin
        chk("rsp_hold_valid", 128'(rsp_valid), 128'(1'b1));
        chk("rsp_hold_data", 128'({rsp_result, rsp_fctrl, rsp_is_single, rsp_tag}), 128'(p_rsp));
      end
      if (rsp_valid && !p_rsp_valid) rise_cyc = cyc;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: tag %0d result %0h with nothing outstanding", rsp_tag, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", 128'(rsp_result), 128'(e.res));
          chk("rsp_fctrl", 128'(rsp_fctrl), 128'(e.fc));
          chk("rsp_is_single", 128'(rsp_is_single), 128'(e.sgl));
          chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
        end
      end
      if (div_strobe_in) begin
        n_strobes++;
        strobe_cyc = cyc;
        chk("strobe_one_cycle", 128'(p_strobe), 128'(1'b0));
        chk("strobe_gated", 128'({p_flush, p_rsp_valid && !p_rsp_ready}), 128'(2'b00));
        chk("strobe_overlap", 128'({s_cnt != 0, div_valid_out}), 128'(2'b00));
        outstanding = 1'b1;
      end
      if (div_valid_out) begin
        chk("div_valid_while_idle", 128'(outstanding), 128'(1'b1));
        outstanding = 1'b0;
      end
      if (flush) sb.delete();
      if (req_valid && req_ready && !flush) begin
        e.res = req_a ^ req_b;
        e.fc  = '{rnd: req_fctrl.rnd, tininess: req_fctrl.tininess, flags: 5'h01};
        e.sgl = req_is_single;
        e.tag = req_tag;
        sb.push_back(e);
        push_cyc = cyc;
      end
      p_strobe    = div_strobe_in;
      p_rsp_valid = rsp_valid;
      p_rsp_ready = rsp_ready;
      p_flush     = flush;
      p_rsp       = {rsp_result, rsp_fctrl, rsp_is_single, rsp_tag};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [TAG_W-1:0] tag, input logic [64:0] a, input logic [64:0] b,
                      output logic rv_at_accept);
    logic ok;
    req_valid     = 1'b1;
    req_a         = a;
    req_b         = b;
    req_tag       = tag;
    req_is_single = 1'($urandom);
    req_fctrl     = float_ctrl_t'(9'($urandom));
    ok            = 1'b0;
    rv_at_accept  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        rv_at_accept = rsp_valid;
        break;
      end
    end
    tick();
    req_valid = 1'b0;
    chk("send_accepted", 128'(ok), 128'(1'b1));
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sb.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, 128'(ok), 128'(1'b1));
  endtask

  task automatic wait_strobe();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (div_strobe_in) begin
        ok = 1'b1;
        break;
      end
    end
    chk("strobe_seen", 128'(ok), 128'(1'b1));
  endtask

  function automatic logic [64:0] rnd65();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rv;
    int   base;
    int   d_cyc;
    rst_n = 0; flush = 0; req_valid = 0; req_a = '0; req_b = '0;
    req_is_single = 0; req_fctrl = '0; req_tag = '0; rsp_ready = 1;
    #2;
    chk("reset_req_ready", 128'(req_ready), 128'(1'b1));
    chk("reset_strobe", 128'(div_strobe_in), 128'(1'b0));
    chk("reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("reset_rsp_data", 128'({rsp_result, rsp_fctrl, rsp_tag}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // Single op: latency and content
    base = n_strobes;
    send(5'd3, 65'h0_3FF0_0000_0000_0000, 65'h0_4000_0000_0000_0000, rv);
    wait_done("t1_done");
    chk("t1_strobe_count", 128'(n_strobes - base), 128'(1));
    chk("t1_push_to_strobe", 128'(strobe_cyc - push_cyc), 128'(2));
    chk("t1_strobe_to_rsp", 128'(rise_cyc - strobe_cyc), 128'(6));

    // Three back-to-back requests into a two-entry queue
    send(5'd1, rnd65(), rnd65(), rv);
    send(5'd2, rnd65(), rnd65(), rv);
    chk("t2_full_ready", 128'(req_ready), 128'(1'b0));
    send(5'd3, rnd65(), rnd65(), rv);
    chk("t2_third_after_pop", 128'(rv), 128'(1'b1));
    wait_done("t2_done");

    // Writeback stall blocks issue of the next op
    rsp_ready = 0;
    send(5'd4, rnd65(), rnd65(), rv);
    send(5'd5, rnd65(), rnd65(), rv);
    for (int i = 0; i < 40 && !rsp_valid; i++) tick();
    chk("t3_rsp_valid", 128'(rsp_valid), 128'(1'b1));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_no_strobe", 128'(div_strobe_in), 128'(1'b0));
    end
    rsp_ready = 1;
    tick();
    chk("t3_strobe_on_ready", 128'(div_strobe_in), 128'(1'b1));
    wait_done("t3_done");

    // Flush while busy with one more op queued; push during drain
    base = n_strobes;
    send(5'd6, rnd65(), rnd65(), rv);
    send(5'd7, rnd65(), rnd65(), rv);
    wait_strobe();
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    send(5'd8, rnd65(), rnd65(), rv);
    d_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_valid_out) begin
        d_cyc = 1;
        break;
      end
    end
    chk("t4_drain_return", 128'(d_cyc), 128'(1));
    chk("t4_no_rsp_in_drain", 128'(rsp_valid), 128'(1'b0));
    @(negedge clk);
    chk("t4_strobe_after_drain", 128'(div_strobe_in), 128'(1'b1));
    wait_done("t4_done");
    chk("t4_strobe_count", 128'(n_strobes - base), 128'(2));

    // Asynchronous reset in the middle of a divide
    send(5'd9, rnd65(), rnd65(), rv);
    send(5'd10, rnd65(), rnd65(), rv);
    wait_strobe();
    #1 rst_n = 0;
    #1;
    chk("t5_reset_strobe", 128'(div_strobe_in), 128'(1'b0));
    chk("t5_reset_rsp_valid", 128'(rsp_valid), 128'(1'b0));
    chk("t5_reset_req_ready", 128'(req_ready), 128'(1'b1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
    base = n_strobes;
    send(5'd11, rnd65(), rnd65(), rv);
    wait_done("t5_done");
    chk("t5_strobe_count", 128'(n_strobes - base), 128'(1));

    // Random traffic with back-pressure and occasional flushes
    for (int i = 0; i < 600; i++) begin
      req_valid     = ($urandom_range(0, 1) == 1);
      req_a         = rnd65();
      req_b         = rnd65();
      req_tag       = TAG_W'($urandom);
      req_is_single = 1'($urandom);
      req_fctrl     = float_ctrl_t'(9'($urandom));
      rsp_ready     = ($urandom_range(0, 9) < 7);
      flush         = ($urandom_range(0, 49) == 0);
      tick();
    end
    req_valid = 0;
    flush     = 0;
    rsp_ready = 1;
    wait_done("rand_drain");
    chk("rand_sb_empty", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
